// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller: default geometry,
// FSM state encoding and line address helper.
package cache_pkg;

    localparam int ADDRESS_WIDTH   = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int LINE_SIZE_BYTES = 64;
    localparam int OFFSET_BITS     = 6;
    localparam int BEATS           = LINE_SIZE_BYTES * 8 / DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_e;

    // Clear the in-line byte offset to get the line base address.
    function automatic logic [ADDRESS_WIDTH-1:0] line_base(
        input logic [ADDRESS_WIDTH-1:0] addr,
        input int unsigned              offset_bits
    );
        return addr & ~((ADDRESS_WIDTH'(1) << offset_bits) - ADDRESS_WIDTH'(1));
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_wb_buffer.sv
// Single-entry capture of a dirty evicted line, with full flag and a sticky
// overflow flag for evictions that arrive while the entry is still occupied.
module wb_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_WIDTH    = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_evict,
    input  logic [ADDRESS_WIDTH-1:0] i_evict_addr,
    input  logic [LINE_WIDTH-1:0]    i_evict_data,
    input  logic                     i_clear,
    output logic                     o_full,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    output logic [LINE_WIDTH-1:0]    o_data,
    output logic                     o_overflow
);
    import cache_pkg::*;

    logic                     full_q, full_d;
    logic                     overflow_q, overflow_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0]    data_q, data_d;

    always_comb begin
        full_d     = full_q;
        overflow_d = overflow_q;
        addr_d     = addr_q;
        data_d     = data_q;
        if (i_clear) full_d = 1'b0;
        // An entry released on this edge can take a new eviction immediately.
        if (i_evict) begin
            if (full_d) begin
                overflow_d = 1'b1;
            end else begin
                full_d = 1'b1;
                addr_d = i_evict_addr;
                data_d = i_evict_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            full_q     <= full_d;
            overflow_q <= overflow_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign o_full     = full_q;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: writes back a buffered dirty line, then fetches a
// missed line beat by beat. Optional CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missed word.
module cache_refill_ctrl #(
    parameter int ADDRESS_WIDTH   = cache_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = cache_pkg::DATA_WIDTH,
    parameter int LINE_SIZE_BYTES = cache_pkg::LINE_SIZE_BYTES,
    parameter int OFFSET_BITS     = cache_pkg::OFFSET_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss,
    input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
    input  logic                         i_evict,
    input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
    input  logic [LINE_SIZE_BYTES*8-1:0] i_evict_data,
    output logic [LINE_SIZE_BYTES*8-1:0] o_memory_line,
    output logic                         o_memory_response,
    output logic                         o_busy,
    output logic                         o_wb_overflow,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_we,
    output logic [ADDRESS_WIDTH-1:0]     mem_req_addr,
    output logic [DATA_WIDTH-1:0]        mem_req_wdata,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]        mem_rsp_rdata
);
    import cache_pkg::*;

    localparam int LINE_W     = LINE_SIZE_BYTES * 8;
    localparam int NBEATS     = LINE_W / DATA_WIDTH;
    localparam int BEAT_W     = $clog2(NBEATS);
    localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    function automatic logic [ADDRESS_WIDTH-1:0] word_addr(
        input logic [ADDRESS_WIDTH-1:0] addr,
        input logic [BEAT_W-1:0]        beat
    );
        return line_base(addr, OFFSET_BITS) + (ADDRESS_WIDTH'(beat) << WORD_SHIFT);
    endfunction

    logic                     wb_full, wb_clear;
    logic [ADDRESS_WIDTH-1:0] wb_addr;
    logic [LINE_W-1:0]        wb_data;

    wb_buffer #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .LINE_WIDTH   (LINE_W)
    ) u_wb_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_evict     (i_evict),
        .i_evict_addr(i_evict_addr),
        .i_evict_data(i_evict_data),
        .i_clear     (wb_clear),
        .o_full      (wb_full),
        .o_addr      (wb_addr),
        .o_data      (wb_data),
        .o_overflow  (o_wb_overflow)
    );

    state_e                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d, start_beat;
    logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [LINE_W-1:0]        line_q, line_d;
    logic                     valid_q, valid_d, we_q, we_d;
    logic                     resp_q, resp_d, busy_q, busy_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     req_fire, rd_done;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic [BEAT_W-1:0] rcv_q, rcv_d;
    assign start_beat = i_miss_addr[OFFSET_BITS-1:WORD_SHIFT];
    assign rd_done    = (rcv_q == LAST_BEAT);
`else
    assign start_beat = '0;
    assign rd_done    = (beat_q == LAST_BEAT);
`endif

    assign req_fire = valid_q && mem_req_ready;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        miss_addr_d = miss_addr_q;
        line_d      = line_q;
        wb_clear    = 1'b0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        rcv_d       = rcv_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A same-cycle eviction lands in the buffer next edge; hold the
                // miss one cycle so the writeback still goes first.
                if (wb_full) begin
                    state_d = WB;
                    beat_d  = '0;
                end else if (i_miss && !i_evict) begin
                    state_d     = RD_REQ;
                    miss_addr_d = i_miss_addr;
                    beat_d      = start_beat;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
                    rcv_d       = '0;
`endif
                end
            end
            WB: begin
                if (req_fire) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        wb_clear = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            RD_REQ: begin
                if (req_fire) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rsp_valid) begin
                    line_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rsp_rdata;
                    beat_d  = beat_q + 1'b1;
                    state_d = rd_done ? RESP : RD_REQ;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
                    rcv_d   = rcv_q + 1'b1;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop.
        valid_d = (state_d == WB) || (state_d == RD_REQ);
        we_d    = (state_d == WB);
        busy_d  = (state_d != IDLE);
        resp_d  = (state_d == RESP);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == WB) begin
            addr_d  = word_addr(wb_addr, beat_d);
            wdata_d = wb_data[int'(beat_d)*DATA_WIDTH +: DATA_WIDTH];
        end else if (state_d == RD_REQ) begin
            addr_d  = word_addr(miss_addr_d, beat_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            miss_addr_q <= '0;
            line_q      <= '0;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            resp_q      <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
            rcv_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            miss_addr_q <= miss_addr_d;
            line_q      <= line_d;
            valid_q     <= valid_d;
            we_q        <= we_d;
            resp_q      <= resp_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
            rcv_q       <= rcv_d;
`endif
        end
    end

    assign o_memory_line     = line_q;
    assign o_memory_response = resp_q;
    assign o_busy            = busy_q;
    assign mem_req_valid     = valid_q;
    assign mem_req_we        = we_q;
    assign mem_req_addr      = addr_q;
    assign mem_req_wdata     = wdata_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: table of refills plus hand-written
// writeback, overflow, mid-refill eviction and reset sequences.
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_miss = 1'b0;
    logic [31:0]  i_miss_addr = '0;
    logic         i_evict = 1'b0;
    logic [31:0]  i_evict_addr = '0;
    logic [511:0] i_evict_data = '0;
    logic [511:0] o_memory_line;
    logic         o_memory_response, o_busy, o_wb_overflow;
    logic         mem_req_valid, mem_req_we;
    logic         mem_req_ready = 1'b1;
    logic [31:0]  mem_req_addr, mem_req_wdata;
    logic         mem_rsp_valid = 1'b0;
    logic [31:0]  mem_rsp_rdata = '0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_miss           (i_miss),
        .i_miss_addr      (i_miss_addr),
        .i_evict          (i_evict),
        .i_evict_addr     (i_evict_addr),
        .i_evict_data     (i_evict_data),
        .o_memory_line    (o_memory_line),
        .o_memory_response(o_memory_response),
        .o_busy           (o_busy),
        .o_wb_overflow    (o_wb_overflow),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_we       (mem_req_we),
        .mem_req_addr     (mem_req_addr),
        .mem_req_wdata    (mem_req_wdata),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_rdata    (mem_rsp_rdata)
    );

    int n_chk = 0, n_fail = 0;
    int resp_cnt = 0, stall_seen = 0, stab_bad = 0, stall_left = 0;
    logic [31:0] stall_addr = '0;
    logic [31:0] log_addr[$], log_wdata[$];
    bit          log_we[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_we = 1'b0;

    // Memory: read data equals the word address, one-cycle response latency.
    always @(posedge clk) begin : mem_model
        logic        rd_fire, stalled;
        logic [31:0] a;
        rd_fire = mem_req_valid && mem_req_ready && !mem_req_we;
        stalled = mem_req_valid && !mem_req_ready;
        a = mem_req_addr;
        if (o_memory_response) resp_cnt++;
        if (mem_req_valid && mem_req_ready) begin
            log_we.push_back(mem_req_we);
            log_addr.push_back(a);
            log_wdata.push_back(mem_req_wdata);
        end
        if (stalled) stall_seen++;
        if (prev_stall && (!mem_req_valid || a !== prev_addr || mem_req_we !== prev_we)) stab_bad++;
        prev_stall = stalled;
        prev_addr  = a;
        prev_we    = mem_req_we;
        #1;
        mem_rsp_valid = rd_fire;
        mem_rsp_rdata = rd_fire ? a : '0;
        if (stall_left > 0 && mem_req_valid && !mem_req_we && mem_req_addr == stall_addr) begin
            mem_req_ready = 1'b0;
            stall_left--;
        end else begin
            mem_req_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] exp_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(4 * k);
        return l;
    endfunction

    function automatic logic [511:0] evict_line(input logic [7:0] seed);
        logic [511:0] l;
        for (int j = 0; j < 64; j++) l[j*8 +: 8] = seed + 8'(j);
        return l;
    endfunction

    function automatic int start_of(input logic [31:0] a);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        return int'(a[5:2]);
`else
        return 0;
`endif
    endfunction

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
    endtask

    task automatic wait_resp(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!o_memory_response && cyc < limit);
        if (!o_memory_response) cyc = -1;
        i_miss = 1'b0;
    endtask

    task automatic run_refill(input logic [31:0] addr, output int lat);
        i_miss      = 1'b1;
        i_miss_addr = addr;
        wait_resp(400, lat);
    endtask

    // Count log entries that are not the expected writeback of a whole line.
    function automatic int wb_errors(input int first, input logic [31:0] base, input logic [511:0] data);
        int bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (first + k >= log_addr.size()) bad++;
            else if (!log_we[first+k] || log_addr[first+k] != base + 32'(4 * k) ||
                     log_wdata[first+k] != data[k*32 +: 32]) bad++;
        end
        return bad;
    endfunction

    function automatic int rd_errors(input int first, input logic [31:0] base, input int st);
        int bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (first + k >= log_addr.size()) bad++;
            else if (log_we[first+k] || log_addr[first+k] != base + 32'(4 * ((st + k) % 16))) bad++;
        end
        return bad;
    endfunction

    typedef struct {
        logic [31:0] miss_addr;
        logic [31:0] stall_addr;
        int          stall_n;
        logic [31:0] exp_base;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, s0, b0, bad;
        logic [511:0] xl, yl;

        vecs[0] = '{32'h0000_1234, 32'h0, 0, 32'h0000_1200, 33};
        vecs[1] = '{32'h0000_1238, 32'h0, 0, 32'h0000_1200, 33};
        vecs[2] = '{32'h2000_0010, 32'h2000_000C, 5, 32'h2000_0000, 38};
        vecs[3] = '{32'hFFFF_FFFC, 32'h0, 0, 32'hFFFF_FFC0, 33};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_resp", o_memory_response, 0);
        chk("rst_ovf", o_wb_overflow, 0);
        chk("rst_line", o_memory_line, 0);
        chk("rst_addr_we_wdata", {mem_req_addr, mem_req_we, mem_req_wdata}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            clear_log();
            stall_addr = vecs[i].stall_addr;
            stall_left = vecs[i].stall_n;
            s0 = stall_seen; b0 = stab_bad; r0 = resp_cnt;
            run_refill(vecs[i].miss_addr, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_line", i), o_memory_line, exp_line(vecs[i].exp_base));
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_line_hold", i), o_memory_line, exp_line(vecs[i].exp_base));
            chk($sformatf("v%0d_resp_pulses", i), resp_cnt - r0, 1);
            chk($sformatf("v%0d_n_req", i), log_addr.size(), 16);
            chk($sformatf("v%0d_rd_order", i), rd_errors(0, vecs[i].exp_base, start_of(vecs[i].miss_addr)), 0);
            chk($sformatf("v%0d_stall_cycles", i), stall_seen - s0, vecs[i].stall_n);
            chk($sformatf("v%0d_req_stable", i), stab_bad - b0, 0);
            chk($sformatf("v%0d_idle", i), o_busy, 0);
        end

        // Eviction together with a miss: writeback must precede the refill.
        clear_log();
        xl = evict_line(8'hA5);
        r0 = resp_cnt;
        i_evict = 1'b1; i_evict_addr = 32'h0000_4000; i_evict_data = xl;
        i_miss = 1'b1; i_miss_addr = 32'h0000_8000;
        @(negedge clk);
        i_evict = 1'b0;
        wait_resp(400, lat);
        chk("ev_resp_seen", lat > 0, 1);
        chk("ev_line", o_memory_line, exp_line(32'h0000_8000));
        repeat (3) @(negedge clk);
        chk("ev_n_req", log_addr.size(), 32);
        chk("ev_wb_first", wb_errors(0, 32'h0000_4000, xl), 0);
        chk("ev_rd_after", rd_errors(16, 32'h0000_8000, 0), 0);
        chk("ev_resp_pulses", resp_cnt - r0, 1);
        chk("ev_no_ovf", o_wb_overflow, 0);

        // Second eviction while the buffer is full is dropped.
        clear_log();
        xl = evict_line(8'h11);
        yl = evict_line(8'h77);
        i_evict = 1'b1; i_evict_addr = 32'h0000_5000; i_evict_data = xl;
        @(negedge clk);
        i_evict_addr = 32'h0000_6000; i_evict_data = yl;
        @(negedge clk);
        i_evict = 1'b0;
        chk("ovf_set", o_wb_overflow, 1);
        repeat (60) @(negedge clk);
        chk("ovf_sticky", o_wb_overflow, 1);
        chk("ovf_n_writes", log_addr.size(), 16);
        chk("ovf_first_line_only", wb_errors(0, 32'h0000_5000, xl), 0);
        chk("ovf_idle", o_busy, 0);

        // Eviction mid-refill is written back after the response.
        clear_log();
        xl = evict_line(8'h3C);
        r0 = resp_cnt;
        i_miss = 1'b1; i_miss_addr = 32'h0000_3000;
        repeat (10) @(negedge clk);
        i_evict = 1'b1; i_evict_addr = 32'h0000_7000; i_evict_data = xl;
        @(negedge clk);
        i_evict = 1'b0;
        wait_resp(400, lat);
        chk("mid_line", o_memory_line, exp_line(32'h0000_3000));
        repeat (30) @(negedge clk);
        chk("mid_n_req", log_addr.size(), 32);
        chk("mid_rd_first", rd_errors(0, 32'h0000_3000, 0), 0);
        chk("mid_wb_after", wb_errors(16, 32'h0000_7000, xl), 0);
        chk("mid_resp_pulses", resp_cnt - r0, 1);

        // Reset while beat 7 of a refill is outstanding.
        clear_log();
        i_miss = 1'b1; i_miss_addr = 32'h0000_1234;
        for (int c = 0; c < 100 && log_addr.size() < 7; c++) @(negedge clk);
        chk("rst_reached_beat7", log_addr.size(), 7);
        r0 = resp_cnt;
        rst = 1'b1; i_miss = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
                               o_busy, o_memory_response, o_wb_overflow}, 0);
        chk("midrst_line", o_memory_line, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_resp", resp_cnt - r0, 0);
        clear_log();
        run_refill(32'h0000_1234, lat);
        chk("restart_latency", lat, 33);
        chk("restart_line", o_memory_line, exp_line(32'h0000_1200));
        repeat (2) @(negedge clk);
        chk("restart_rd_order", rd_errors(0, 32'h0000_1200, start_of(32'h0000_1234)), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
